soc_gen: RTL

- Originating end of the POWERLINK SoC path: a managing-node transmitter that emits a Start-of-Cycle Ethernet frame on an RMII transmit interface.
- Emits one frame every CYCLE_CLKS clocks.
- Drives the segment that the SoC retransmit/jitter-compensation chain receives, so bench and board can run without an external MN.
- Fast Ethernet only: clk is the 50 MHz RMII reference, one dibit per clock.

---
 rtl/soc_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/soc_gen.sv
// POWERLINK Start-of-Cycle frame generator on an RMII transmit interface.
// Emits a 288-clock SoC frame (preamble, 60-byte payload, FCS) once per period.
module soc_gen #(
  parameter int unsigned CYCLE_CLKS    = 50000,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter logic [47:0] SRC_MAC       = 48'h00111E0000F0,
  parameter logic [7:0]  MN_NODE       = 8'hF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        rm_tx_en,
  output logic [1:0]  rm_tx_data,
  output logic        soc_pulse,
  output logic        busy,
  output logic [31:0] soc_count
);

  // Frame is 288 clocks; keep at least a 48-clock gap before the next one.
  localparam int unsigned MinPeriod = 336;
  localparam int unsigned Period    = (CYCLE_CLKS > MinPeriod) ? CYCLE_CLKS : MinPeriod;
  localparam logic [COUNTER_WIDTH-1:0] PeriodLast = COUNTER_WIDTH'(Period - 1);

  typedef enum logic [1:0] {StIdle, StPre, StData, StFcs} state_e;

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]               idx_q, idx_d;
  logic [31:0]              crc_q, crc_d;
  logic [31:0]              rel_q, rel_d;
  logic [31:0]              count_q, count_d;
  logic                     tx_en_q, tx_en_d;
  logic [1:0]               tx_data_q, tx_data_d;
  logic                     pulse_q, pulse_d;

  logic       frame_start;
  logic [7:0] cur_byte;
  logic [1:0] data_dibit;
  logic [31:0] fcs_val;
  logic [1:0] fcs_dibit;

  // Payload byte at offset k from the destination MAC.
  function automatic logic [7:0] data_byte(input logic [5:0] k, input logic [31:0] rel);
    logic [7:0] b;
    b = 8'h00;
    case (k)
      6'd0:  b = 8'h01;
      6'd1:  b = 8'h11;
      6'd2:  b = 8'h1E;
      6'd5:  b = 8'h01;
      6'd6:  b = SRC_MAC[47:40];
      6'd7:  b = SRC_MAC[39:32];
      6'd8:  b = SRC_MAC[31:24];
      6'd9:  b = SRC_MAC[23:16];
      6'd10: b = SRC_MAC[15:8];
      6'd11: b = SRC_MAC[7:0];
      6'd12: b = 8'h88;
      6'd13: b = 8'hAB;
      6'd14: b = 8'h01;
      6'd15: b = 8'hFF;
      6'd16: b = MN_NODE;
      // RelativeTime low word, little-endian; high word is zero.
      6'd28: b = rel[7:0];
      6'd29: b = rel[15:8];
      6'd30: b = rel[23:16];
      6'd31: b = rel[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign frame_start = enable && (cnt_q == '0) && (state_q == StIdle);
  assign cur_byte    = data_byte(idx_q[7:2], rel_q);
  assign data_dibit  = cur_byte[{idx_q[1:0], 1'b0} +: 2];
  assign fcs_val     = ~crc_q;
  assign fcs_dibit   = fcs_val[{idx_q[3:0], 1'b0} +: 2];

  // Period counter: held at zero while disabled, wraps at the effective period.
  always_comb begin
    cnt_d = '0;
    if (enable) begin
      if (cnt_q == PeriodLast) cnt_d = '0;
      else                     cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  // Frame sequencer: idx_q is the index of the next dibit within the current state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    rel_d     = rel_q;
    count_d   = count_q;
    tx_en_d   = 1'b0;
    tx_data_d = 2'b00;
    pulse_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d   = StPre;
          idx_d     = 8'd1;
          tx_en_d   = 1'b1;
          tx_data_d = 2'b01;
          pulse_d   = 1'b1;
          rel_d     = count_q;
          crc_d     = 32'hFFFFFFFF;
        end
      end
      StPre: begin
        tx_en_d = 1'b1;
        // Last preamble dibit is the top of the SFD (0xD5).
        if (idx_q == 8'd31) begin
          tx_data_d = 2'b11;
          state_d   = StData;
          idx_d     = 8'd0;
        end else begin
          tx_data_d = 2'b01;
          idx_d     = idx_q + 8'd1;
        end
      end
      StData: begin
        tx_en_d   = 1'b1;
        tx_data_d = data_dibit;
        crc_d     = crc_dibit(crc_q, data_dibit);
        if (idx_q == 8'd239) begin
          state_d = StFcs;
          idx_d   = 8'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      StFcs: begin
        tx_en_d   = 1'b1;
        tx_data_d = fcs_dibit;
        if (idx_q == 8'd15) begin
          state_d = StIdle;
          idx_d   = 8'd0;
          count_d = count_q + 32'd1;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered RMII outputs; reset aborts any frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= 8'd0;
      crc_q     <= 32'hFFFFFFFF;
      rel_q     <= 32'd0;
      count_q   <= 32'd0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 2'b00;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      rel_q     <= rel_d;
      count_q   <= count_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      pulse_q   <= pulse_d;
    end
  end

  assign rm_tx_en   = tx_en_q;
  assign rm_tx_data = tx_data_q;
  assign soc_pulse  = pulse_q;
  assign busy       = tx_en_q;
  assign soc_count  = count_q;

endmodule
